// File: rtl/xv_pkg.sv
// Shared definitions for the VRAM register controller:
// register numbers, FSM state type and a byte-select helper.
package xv;

  localparam logic [3:0] XR_RD_INCR = 4'd0;
  localparam logic [3:0] XR_RD_ADDR = 4'd1;
  localparam logic [3:0] XR_WR_INCR = 4'd2;
  localparam logic [3:0] XR_WR_ADDR = 4'd3;
  localparam logic [3:0] XR_DATA    = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_REQ = 2'd1,
    ST_RD_REQ = 2'd2
  } vram_ctrl_state_t;

  function automatic logic [7:0] pick_byte(
    input logic [15:0] w,
    input logic        odd
  );
    return odd ? w[7:0] : w[15:8];
  endfunction

endpackage

// File: rtl/vram_reg_ctrl.sv
// Byte-wide register front end with auto-increment VRAM read/write requests.
// Build option VRAM_REG_READBACK_EN: regs 0-3 become readable.
module vram_reg_ctrl
  import xv::*;
(
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        write_strobe_i,
  input  logic        read_strobe_i,
  input  logic [3:0]  reg_num_i,
  input  logic        bytesel_i,
  input  logic [7:0]  bytedata_i,
  output logic [7:0]  rd_byte_o,
  output logic        busy_o,
  output logic        wr_overrun_o,
  output logic        vram_sel_o,
  output logic        vram_wr_o,
  output logic [15:0] vram_addr_o,
  output logic [15:0] vram_data_o,
  input  logic        vram_ack_i,
  input  logic [15:0] vram_data_i
);

  vram_ctrl_state_t state;

  logic [15:0] rd_incr;
  logic [15:0] rd_addr;
  logic [15:0] wr_incr;
  logic [15:0] wr_addr;
  logic [15:0] rd_word;
  logic [15:0] wr_req_addr;
  logic [15:0] wr_req_data;
  logic [15:0] rd_req_addr;
  logic [7:0]  hold;
  logic [7:0]  rb;
  logic        wr_pend;
  logic        rd_pend;
  logic        rd_restart;
  logic        commit;
  logic        rd_odd;
  logic        rd_busy;
  logic [15:0] word;

  assign commit = write_strobe_i & bytesel_i;
  assign word   = {hold, bytedata_i};
  assign rd_odd = read_strobe_i & bytesel_i
                & (reg_num_i == XR_DATA);

  // A read is "in flight" also in the cycle the FSM latches its address.
  assign rd_busy = ((state == ST_RD_REQ) & ~vram_ack_i)
                 | ((state == ST_IDLE) & ~wr_pend & rd_pend);

  always_comb begin
    rb = 8'h00;
    unique case (1'b1)
      (reg_num_i == XR_DATA):
        rb = pick_byte(rd_word, bytesel_i);
`ifdef VRAM_REG_READBACK_EN
      (reg_num_i == XR_RD_INCR):
        rb = pick_byte(rd_incr, bytesel_i);
      (reg_num_i == XR_RD_ADDR):
        rb = pick_byte(rd_addr, bytesel_i);
      (reg_num_i == XR_WR_INCR):
        rb = pick_byte(wr_incr, bytesel_i);
      (reg_num_i == XR_WR_ADDR):
        rb = pick_byte(wr_addr, bytesel_i);
      default: rb = 8'h00;
`else
      default: rb = 8'h00;
`endif
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= ST_IDLE;
      rd_incr      <= '0;
      rd_addr      <= '0;
      wr_incr      <= '0;
      wr_addr      <= '0;
      rd_word      <= '0;
      wr_req_addr  <= '0;
      wr_req_data  <= '0;
      rd_req_addr  <= '0;
      hold         <= '0;
      wr_pend      <= 1'b0;
      rd_pend      <= 1'b0;
      rd_restart   <= 1'b0;
      wr_overrun_o <= 1'b0;
      rd_byte_o    <= '0;
    end else begin
      if (write_strobe_i && !bytesel_i)
        hold <= bytedata_i;

      if (read_strobe_i)
        rd_byte_o <= rb;

      unique case (state)
        ST_IDLE: begin
          if (wr_pend) begin
            state <= ST_WR_REQ;
          end else if (rd_pend) begin
            state       <= ST_RD_REQ;
            rd_req_addr <= rd_addr;
          end
        end
        ST_WR_REQ: begin
          if (vram_ack_i) begin
            wr_pend <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_RD_REQ: begin
          if (vram_ack_i) begin
            if (rd_restart) begin
              rd_restart <= 1'b0;
            end else begin
              rd_word <= vram_data_i;
              rd_pend <= 1'b0;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Host actions come last so they win over a same-cycle ack.
      if (rd_odd) begin
        rd_addr <= rd_addr + rd_incr;
        rd_pend <= 1'b1;
      end

      if (commit) begin
        unique case (1'b1)
          (reg_num_i == XR_RD_INCR): rd_incr <= word;
          (reg_num_i == XR_WR_INCR): wr_incr <= word;
          (reg_num_i == XR_WR_ADDR): wr_addr <= word;
          (reg_num_i == XR_RD_ADDR): begin
            rd_addr <= word;
            rd_pend <= 1'b1;
            if (rd_busy)
              rd_restart <= 1'b1;
          end
          (reg_num_i == XR_DATA): begin
            if (wr_pend) begin
              wr_overrun_o <= 1'b1;
            end else begin
              wr_req_addr <= wr_addr;
              wr_req_data <= word;
              wr_addr     <= wr_addr + wr_incr;
              wr_pend     <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy_o      = wr_pend | rd_pend;
  assign vram_sel_o  = (state != ST_IDLE);
  assign vram_wr_o   = (state == ST_WR_REQ);
  assign vram_addr_o = (state == ST_WR_REQ) ? wr_req_addr
                     : (state == ST_RD_REQ) ? rd_req_addr
                     : 16'h0000;
  assign vram_data_o = (state == ST_WR_REQ) ? wr_req_data
                                            : 16'h0000;

endmodule

// File: tb/tb_vram_reg_ctrl.sv
// Bench for vram_reg_ctrl: register table plus a VRAM responder
// that checks each request against a queue of expected requests.
module tb_vram_reg_ctrl;
  import xv::*;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        write_strobe_i;
  logic        read_strobe_i;
  logic [3:0]  reg_num_i;
  logic        bytesel_i;
  logic [7:0]  bytedata_i;
  logic [7:0]  rd_byte_o;
  logic        busy_o;
  logic        wr_overrun_o;
  logic        vram_sel_o;
  logic        vram_wr_o;
  logic [15:0] vram_addr_o;
  logic [15:0] vram_data_o;
  logic        vram_ack_i;
  logic [15:0] vram_data_i;

  vram_reg_ctrl dut (
    .clk            (clk),
    .reset_n_i      (reset_n_i),
    .write_strobe_i (write_strobe_i),
    .read_strobe_i  (read_strobe_i),
    .reg_num_i      (reg_num_i),
    .bytesel_i      (bytesel_i),
    .bytedata_i     (bytedata_i),
    .rd_byte_o      (rd_byte_o),
    .busy_o         (busy_o),
    .wr_overrun_o   (wr_overrun_o),
    .vram_sel_o     (vram_sel_o),
    .vram_wr_o      (vram_wr_o),
    .vram_addr_o    (vram_addr_o),
    .vram_data_o    (vram_data_o),
    .vram_ack_i     (vram_ack_i),
    .vram_data_i    (vram_data_i)
  );

  always #5 clk = ~clk;

`ifdef VRAM_REG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  typedef struct {
    logic [3:0]  rn;
    logic [15:0] w;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;

  req_t expq[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   ack_dly = 3;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wr_byte(input logic [3:0] rn,
                         input logic bs,
                         input logic [7:0] d);
    write_strobe_i = 1'b1;
    reg_num_i      = rn;
    bytesel_i      = bs;
    bytedata_i     = d;
    @(posedge clk); #1;
    write_strobe_i = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] rn,
                        input logic [15:0] w);
    wr_byte(rn, 1'b0, w[15:8]);
    wr_byte(rn, 1'b1, w[7:0]);
  endtask

  task automatic rd_byte(input logic [3:0] rn,
                         input logic bs,
                         output logic [7:0] b);
    read_strobe_i = 1'b1;
    reg_num_i     = rn;
    bytesel_i     = bs;
    @(posedge clk); #1;
    read_strobe_i = 1'b0;
    b = rd_byte_o;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy_o || vram_sel_o) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++;
    if (busy_o || vram_sel_o) begin
      n_bad++;
      $display("FAIL idle_timeout: busy %b sel %b", busy_o, vram_sel_o);
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_sel"},  vram_sel_o,   0);
    chk({tag, "_wr"},   vram_wr_o,    0);
    chk({tag, "_addr"}, vram_addr_o,  0);
    chk({tag, "_data"}, vram_data_o,  0);
    chk({tag, "_busy"}, busy_o,       0);
    chk({tag, "_ovr"},  wr_overrun_o, 0);
    chk({tag, "_rdb"},  rd_byte_o,    0);
  endtask

  // VRAM responder: check request, hold for ack_dly cycles, then ack.
  initial begin
    req_t        e;
    logic [15:0] a, d;
    logic        w, live, unstable;
    vram_ack_i  = 1'b0;
    vram_data_i = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (vram_sel_o) begin
        a = vram_addr_o;
        w = vram_wr_o;
        d = vram_data_o;
        e = '{1'b0, 16'h0000, 16'h0000};
        n_cmp++;
        if (expq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_req: wr %b addr %h, none expected",
                   w, a);
        end else begin
          e = expq.pop_front();
          chk("req_wr",   w, e.wr);
          chk("req_addr", a, e.addr);
          if (e.wr)
            chk("req_data", d, e.data);
        end
        live     = 1'b1;
        unstable = 1'b0;
        for (int i = 0; i < ack_dly; i++) begin
          @(posedge clk); #1;
          if (!vram_sel_o) begin
            live = 1'b0;
            break;
          end
          if ({vram_wr_o, vram_addr_o, vram_data_o} !== {w, a, d})
            unstable = 1'b1;
        end
        if (live) begin
          chk("req_stable", unstable, 0);
          vram_ack_i  = 1'b1;
          vram_data_i = e.wr ? 16'h0000 : e.data;
          @(posedge clk); #1;
          vram_ack_i  = 1'b0;
          vram_data_i = 16'h0000;
          chk("sel_drop", vram_sel_o, 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[6];
    logic [7:0] b;
    logic [3:0] rns[6];
    logic [15:0] ws[6];

    rns = '{XR_RD_INCR, XR_WR_INCR, XR_WR_ADDR, 4'd5, 4'd9, 4'd15};
    ws  = '{16'h1357, 16'h2468, 16'h9ABC, 16'hFFFF, 16'h0102, 16'hA5A5};
    for (int i = 0; i < 6; i++) begin
      tbl[i].rn = rns[i];
      tbl[i].w  = ws[i];
      tbl[i].hi = (RB && rns[i] < 4) ? ws[i][15:8] : 8'h00;
      tbl[i].lo = (RB && rns[i] < 4) ? ws[i][7:0]  : 8'h00;
    end

    reset_n_i      = 1'b0;
    write_strobe_i = 1'b0;
    read_strobe_i  = 1'b0;
    reg_num_i      = 4'd0;
    bytesel_i      = 1'b0;
    bytedata_i     = 8'h00;
    #3;
    chk_outs_zero("rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    @(posedge clk); #1;

    rd_byte(XR_RD_ADDR, 1'b0, b); chk("rst_rdaddr_hi", b, 0);
    rd_byte(XR_RD_ADDR, 1'b1, b); chk("rst_rdaddr_lo", b, 0);

    for (int i = 0; i < 6; i++) begin
      wr_reg(tbl[i].rn, tbl[i].w);
      rd_byte(tbl[i].rn, 1'b0, b); chk("tbl_hi", b, tbl[i].hi);
      rd_byte(tbl[i].rn, 1'b1, b); chk("tbl_lo", b, tbl[i].lo);
    end
    chk("tbl_no_busy", busy_o, 0);

    // Two writes with auto-increment, plus request latency.
    wr_reg(XR_WR_INCR, 16'h0001);
    wr_reg(XR_WR_ADDR, 16'h1000);
    expq.push_back('{1'b1, 16'h1000, 16'hABCD});
    wr_byte(XR_DATA, 1'b0, 8'hAB);
    wr_byte(XR_DATA, 1'b1, 8'hCD);
    chk("lat_n1_sel", vram_sel_o, 0);
    chk("lat_n1_busy", busy_o, 1);
    @(posedge clk); #1;
    chk("lat_n2_sel", vram_sel_o, 1);
    chk("lat_n2_wr", vram_wr_o, 1);
    wait_idle();
    expq.push_back('{1'b1, 16'h1001, 16'h1234});
    wr_reg(XR_DATA, 16'h1234);
    wait_idle();

    // Second DATA word while the first is pending is dropped.
    chk("ovr_clear", wr_overrun_o, 0);
    expq.push_back('{1'b1, 16'h1002, 16'h7777});
    wr_reg(XR_DATA, 16'h7777);
    wr_reg(XR_DATA, 16'h8888);
    chk("ovr_set", wr_overrun_o, 1);
    wait_idle();
    chk("ovr_sticky", wr_overrun_o, 1);
    chk("wr_q_empty", expq.size(), 0);
    rd_byte(XR_WR_ADDR, 1'b0, b); chk("wraddr_hi", b, RB ? 8'h10 : 8'h00);
    rd_byte(XR_WR_ADDR, 1'b1, b); chk("wraddr_lo", b, RB ? 8'h03 : 8'h00);

    // Prefetch with wrap on the post-read increment.
    wr_reg(XR_RD_INCR, 16'h0002);
    expq.push_back('{1'b0, 16'hFFFF, 16'h5AA5});
    wr_reg(XR_RD_ADDR, 16'hFFFF);
    wait_idle();
    rd_byte(XR_DATA, 1'b0, b); chk("rd_hi", b, 8'h5A);
    expq.push_back('{1'b0, 16'h0001, 16'h0000});
    rd_byte(XR_DATA, 1'b1, b); chk("rd_lo", b, 8'hA5);
    chk("rd_busy", busy_o, 1);
    wait_idle();
    rd_byte(XR_DATA, 1'b0, b); chk("rd_wrap_hi", b, 8'h00);

    // RD_ADDR rewritten mid-read: first data discarded.
    expq.push_back('{1'b0, 16'h0020, 16'h1111});
    expq.push_back('{1'b0, 16'h0010, 16'h2222});
    wr_reg(XR_RD_ADDR, 16'h0020);
    wr_reg(XR_RD_ADDR, 16'h0010);
    wait_idle();
    rd_byte(XR_DATA, 1'b0, b); chk("rst_rd_hi", b, 8'h22);
    expq.push_back('{1'b0, 16'h0012, 16'h3C3C});
    rd_byte(XR_DATA, 1'b1, b); chk("rst_rd_lo", b, 8'h22);
    wait_idle();
    rd_byte(XR_DATA, 1'b0, b); chk("rd_next_hi", b, 8'h3C);

    // Write and read both pending when the FSM returns to idle.
    ack_dly = 10;
    expq.push_back('{1'b0, 16'h0060, 16'hDEAD});
    expq.push_back('{1'b1, 16'h1003, 16'h4242});
    expq.push_back('{1'b0, 16'h0050, 16'hBEEF});
    wr_reg(XR_RD_ADDR, 16'h0060);
    wr_reg(XR_DATA,    16'h4242);
    wr_reg(XR_RD_ADDR, 16'h0050);
    wait_idle();
    ack_dly = 3;
    rd_byte(XR_DATA, 1'b0, b); chk("prio_hi", b, 8'hBE);
    expq.push_back('{1'b0, 16'h0052, 16'h0000});
    rd_byte(XR_DATA, 1'b1, b); chk("prio_lo", b, 8'hEF);
    wait_idle();
    chk("prio_q_empty", expq.size(), 0);

    // Asynchronous reset during an outstanding write.
    ack_dly = 10;
    expq.push_back('{1'b1, 16'h1004, 16'h5555});
    wr_reg(XR_DATA, 16'h5555);
    @(posedge clk); #1;
    chk("pre_rst_sel", vram_sel_o, 1);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk_outs_zero("mid_rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    ack_dly   = 3;
    @(posedge clk); #1;
    rd_byte(XR_RD_ADDR, 1'b0, b); chk("post_rd_hi", b, 0);
    rd_byte(XR_RD_ADDR, 1'b1, b); chk("post_rd_lo", b, 0);
    rd_byte(XR_WR_ADDR, 1'b1, b); chk("post_wr_lo", b, 0);
    chk("post_busy", busy_o, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("final_q_empty", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
